reflet_bus_initiator: RTL and testbench

REFLET_BUS_INITIATOR -- requirements
Module: reflet_bus_initiator

---
 rtl/reflet_bus_initiator.sv | 177 +++++++++++++++++
 tb/tb_reflet_bus_initiator.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_bus_initiator.sv
// reflet_bus_initiator
// Turns byte-burst commands into single-byte accesses on a simple
// peripheral bus (enable / address / write strobe / data in / data out).
// Writes take two cycles per byte and reads take three. Every bus-facing
// output and every handshake flag comes straight from a register.
module reflet_bus_initiator #(
    parameter int base_addr_size = 16,
    parameter int len_size       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [base_addr_size-1:0] cmd_addr,
    input  logic [len_size-1:0]       cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [7:0]                rsp_data,
    output logic                      busy,
    output logic                      bus_enable,
    output logic [base_addr_size-1:0] bus_addr,
    output logic [7:0]                bus_wdata,
    input  logic [7:0]                bus_rdata,
    output logic                      bus_write_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WSTROBE,
        S_RADDR,
        S_RCAPTURE,
        S_RHOLD
    } state_t;

    // Output flags that are a pure function of the state. They are
    // registered together with the state so they never glitch.
    typedef struct packed {
        logic cmd_ready;
        logic wr_ready;
        logic rsp_valid;
        logic busy;
        logic bus_enable;
        logic bus_write_en;
    } flags_t;

    localparam logic [base_addr_size-1:0] ADDR_ONE  = {{(base_addr_size-1){1'b0}}, 1'b1};
    localparam logic [len_size-1:0]       COUNT_ONE = {{(len_size-1){1'b0}}, 1'b1};

    state_t                      r_state;
    flags_t                      r_flags;
    logic [base_addr_size-1:0]   r_addr;
    logic [len_size-1:0]         r_count;
    logic [7:0]                  r_wdata;
    logic [7:0]                  r_rsp_data;

    // Flag values to present while sitting in state s.
    function automatic flags_t flags_for(state_t s);
        flags_t f;
        f = '0;
        case (s)
            S_IDLE: begin
                f.cmd_ready = 1'b1;
            end
            S_WDATA: begin
                f.wr_ready = 1'b1;
                f.busy     = 1'b1;
            end
            S_WSTROBE: begin
                f.busy         = 1'b1;
                f.bus_enable   = 1'b1;
                f.bus_write_en = 1'b1;
            end
            S_RADDR, S_RCAPTURE: begin
                f.busy       = 1'b1;
                f.bus_enable = 1'b1;
            end
            S_RHOLD: begin
                f.busy      = 1'b1;
                f.rsp_valid = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    // Burst sequencer: state, output flags, address/count and data registers.
    // NOTE: every register here is written with non-blocking assignments so
    // all of them update together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_flags    <= flags_for(S_IDLE);
            // NOTE: the data registers are cleared as well so the bus address,
            // write data and read data are defined right after reset.
            r_addr     <= '0;
            r_count    <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_count <= cmd_len;
                        if (cmd_write) begin
                            r_state <= S_WDATA;
                            r_flags <= flags_for(S_WDATA);
                        end else begin
                            r_state <= S_RADDR;
                            r_flags <= flags_for(S_RADDR);
                        end
                    end
                end
                S_WDATA: begin
                    if (wr_valid) begin
                        r_wdata <= wr_data;
                        r_state <= S_WSTROBE;
                        r_flags <= flags_for(S_WSTROBE);
                    end
                end
                S_WSTROBE: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                        r_flags <= flags_for(S_IDLE);
                    end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_count <= r_count - COUNT_ONE;
                        r_state <= S_WDATA;
                        r_flags <= flags_for(S_WDATA);
                    end
                end
                S_RADDR: begin
                    r_state <= S_RCAPTURE;
                    r_flags <= flags_for(S_RCAPTURE);
                end
                S_RCAPTURE: begin
                    r_rsp_data <= bus_rdata;
                    r_state    <= S_RHOLD;
                    r_flags    <= flags_for(S_RHOLD);
                end
                S_RHOLD: begin
                    if (rsp_ready) begin
                        if (r_count == '0) begin
                            r_state <= S_IDLE;
                            r_flags <= flags_for(S_IDLE);
                        end else begin
                            r_addr  <= r_addr + ADDR_ONE;
                            r_count <= r_count - COUNT_ONE;
                            r_state <= S_RADDR;
                            r_flags <= flags_for(S_RADDR);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

    assign cmd_ready    = r_flags.cmd_ready;
    assign wr_ready     = r_flags.wr_ready;
    assign rsp_valid    = r_flags.rsp_valid;
    assign busy         = r_flags.busy;
    assign bus_enable   = r_flags.bus_enable;
    assign bus_write_en = r_flags.bus_write_en;
    assign bus_addr     = r_addr;
    assign bus_wdata    = r_wdata;
    assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_reflet_bus_initiator.sv
// Testbench for reflet_bus_initiator: directed burst table, hand-written
// corner sequences and random bursts checked against a byte-array model.
module tb_reflet_bus_initiator;

    localparam int AW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [7:0]    wr_data;
    logic          rsp_valid, rsp_ready;
    logic [7:0]    rsp_data;
    logic          busy, bus_enable, bus_write_en;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    reflet_bus_initiator #(.base_addr_size(AW), .len_size(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .bus_enable(bus_enable), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_write_en(bus_write_en)
    );

    // Initial memory image shared by the peripheral and the reference model.
    function automatic logic [7:0] init_byte(input int i);
        if (i == 32'hFF04) return 8'hA5;
        if (i == 32'hFF05) return 8'h5A;
        return 8'(i * 37 + (i >> 8));
    endfunction

    // Peripheral side: memory, strobe log, protocol monitor, cycle counter.
    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } stb_t;

    logic [7:0] mem [0:65535];
    stb_t       stb_q[$];
    int         illegal_cnt = 0;
    int         cyc = 0;

    assign bus_rdata = mem[bus_addr];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (bus_enable === 1'b1 && bus_write_en === 1'b1) begin
                stb_q.push_back('{a: bus_addr, d: bus_wdata});
                mem[bus_addr] = bus_wdata;
            end
            if (bus_write_en === 1'b1 && bus_enable !== 1'b1) illegal_cnt = illegal_cnt + 1;
        end
    end

    // Reference model: what the memory should contain after each burst.
    logic [7:0] ref_mem [0:65535];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"},    cmd_ready, 1);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_bus_enable"},   bus_enable, 0);
        check({tag, "_bus_write_en"}, bus_write_en, 0);
        check({tag, "_wr_ready"},     wr_ready, 0);
        check({tag, "_rsp_valid"},    rsp_valid, 0);
        check({tag, "_bus_addr"},     bus_addr, 0);
        check({tag, "_bus_wdata"},    bus_wdata, 0);
        check({tag, "_rsp_data"},     rsp_data, 0);
    endtask

    // One complete burst. stall = cycles the bench withholds wr_valid /
    // rsp_ready once the DUT is ready; exp_cycles < 0 means derive the
    // cycle count from the 2-per-write / 3-per-read byte rule.
    task automatic do_burst(input bit wr, input logic [AW-1:0] addr, input int len,
                            input bit rnd, input logic [7:0] dbase, input int stall,
                            input int exp_cycles, input string tag);
        int            n;
        int            c0;
        int            total_stall;
        int            s;
        int            budget;
        int            base;
        int            want;
        logic [7:0]    d;
        logic [AW-1:0] ea;
        logic [AW-1:0] exp_a [16];
        logic [7:0]    exp_d [16];

        n = len + 1;
        total_stall = 0;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin tick(); budget++; end
        if (cmd_ready !== 1'b1) begin check({tag, "_idle_timeout"}, 0, 1); return; end

        base = stb_q.size();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LW'(len);
        tick();
        cmd_valid = 1'b0;
        c0 = cyc;

        for (int i = 0; i < n; i++) begin
            s  = rnd ? int'($urandom_range(0, 3)) : stall;
            total_stall += s;
            ea = addr + AW'(i);
            if (wr) begin
                d = rnd ? 8'($urandom) : 8'(dbase + 8'(i * 17));
                budget = 0;
                while (wr_ready !== 1'b1 && budget < 20) begin tick(); budget++; end
                if (wr_ready !== 1'b1) begin check({tag, "_wr_ready_timeout"}, 0, 1); return; end
                repeat (s) tick();
                wr_valid = 1'b1; wr_data = d;
                tick();
                wr_valid = 1'b0;
                ref_mem[ea] = d;
                exp_a[i] = ea;
                exp_d[i] = d;
            end else begin
                d = ref_mem[ea];
                budget = 0;
                while (rsp_valid !== 1'b1 && budget < 20) begin tick(); budget++; end
                if (rsp_valid !== 1'b1) begin check({tag, "_rsp_valid_timeout"}, 0, 1); return; end
                for (int k = 0; k < s; k++) begin
                    check({tag, "_rsp_hold"}, rsp_data, d);
                    tick();
                end
                check({tag, "_rsp_data"}, rsp_data, d);
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
            end
        end

        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin tick(); budget++; end
        want = (exp_cycles >= 0) ? exp_cycles : n * (wr ? 2 : 3) + total_stall;
        check({tag, "_cycles"}, cyc - c0, want);
        check({tag, "_strobes"}, stb_q.size() - base, wr ? n : 0);
        if (wr && stb_q.size() - base == n) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_stb_addr"}, stb_q[base + i].a, exp_a[i]);
                check({tag, "_stb_data"}, stb_q[base + i].d, exp_d[i]);
            end
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        int            len;
        logic [7:0]    dbase;
        int            stall;
        int            exp_cycles;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int base;

        // write FF08..FF0A (11,22,33); read FF04/FF05 (A5,5A) stalled 5 each;
        // write across the top of memory; read back across the wrap;
        // full 16-byte write with 1-cycle stalls and its read-back; 1-byte read.
        vecs[0] = '{1'b1, 16'hFF08,  2, 8'h11, 0,  6};
        vecs[1] = '{1'b0, 16'hFF04,  1, 8'h00, 5, 16};
        vecs[2] = '{1'b1, 16'hFFFF,  1, 8'h77, 0,  4};
        vecs[3] = '{1'b0, 16'hFFFE,  2, 8'h00, 0,  9};
        vecs[4] = '{1'b1, 16'h1234, 15, 8'h01, 1, 48};
        vecs[5] = '{1'b0, 16'h1234, 15, 8'h00, 0, 48};
        vecs[6] = '{1'b0, 16'h0100,  0, 8'h00, 2,  5};

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b1;
        tick();

        for (int v = 0; v < 7; v++)
            do_burst(vecs[v].wr, vecs[v].addr, vecs[v].len, 1'b0, vecs[v].dbase,
                     vecs[v].stall, vecs[v].exp_cycles, $sformatf("vec%0d", v));

        // Write data withheld for 10 cycles: the bus stays quiet.
        base = stb_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h4000; cmd_len = '0;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("stall_bus_enable", bus_enable, 0);
            check("stall_bus_write_en", bus_write_en, 0);
            check("stall_busy", busy, 1);
            tick();
        end
        wr_valid = 1'b1; wr_data = 8'h3C;
        tick();
        wr_valid = 1'b0;
        check("stall_strobe_en", {bus_enable, bus_write_en}, 2'b11);
        check("stall_strobe_addr", bus_addr, 16'h4000);
        check("stall_strobe_data", bus_wdata, 8'h3C);
        tick();
        check("stall_done_idle", {cmd_ready, busy}, 2'b10);
        check("stall_strobe_count", stb_q.size() - base, 1);
        ref_mem[16'h4000] = 8'h3C;

        // Command held valid while busy is only taken once back in IDLE.
        base = stb_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h5000; cmd_len = '0;
        tick();
        cmd_addr = 16'h6000;
        wr_valid = 1'b1; wr_data = 8'hA1;
        check("hold_cmd_ready_wdata", cmd_ready, 0);
        tick();
        wr_data = 8'hB2;
        check("hold_cmd_ready_wstrobe", cmd_ready, 0);
        tick();
        check("hold_cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick();
        check("hold_strobe_count", stb_q.size() - base, 2);
        if (stb_q.size() - base == 2) begin
            check("hold_first_addr", stb_q[base].a, 16'h5000);
            check("hold_first_data", stb_q[base].d, 8'hA1);
            check("hold_second_addr", stb_q[base + 1].a, 16'h6000);
            check("hold_second_data", stb_q[base + 1].d, 8'hB2);
        end
        ref_mem[16'h5000] = 8'hA1;
        ref_mem[16'h6000] = 8'hB2;

        // Reset during the strobe of byte 2 of a 4-byte write burst.
        base = stb_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h7000; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hC0;
        tick();
        wr_data = 8'hC1;
        tick();
        tick();
        check("rst_mid_in_strobe", {bus_enable, bus_write_en, bus_addr}, {2'b11, 16'h7001});
        reset = 1'b0;
        tick();
        check_reset_vals("rst_mid");
        reset = 1'b1;
        wr_data = 8'hC2;
        repeat (6) tick();
        wr_valid = 1'b0;
        check("rst_mid_strobe_count", stb_q.size() - base, 2);
        check("rst_mid_idle", {cmd_ready, busy}, 2'b10);
        ref_mem[16'h7000] = 8'hC0;
        ref_mem[16'h7001] = 8'hC1;

        // Random bursts, biased towards the top of the address space.
        for (int r = 0; r < 40; r++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                             : AW'($urandom);
            do_burst(1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 15)),
                     1'b1, 8'h00, 0, -1, "rnd");
        end

        check("no_write_en_without_enable", illegal_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
